fifo_bank_salida: RTL and testbench
===================================

Name: fifo_bank_salida

Overview:
- Bank of four independent output FIFOs on the far side of the 4-to-4 arbiter.
- Accepts the arbiter's one-hot Push strobes with the shared data word.
- Returns per-FIFO FIFO_empty and Almost_full status, which throttles the arbiter's traffic.
- Downstream consumers drain each FIFO with their own Pop strobe; each FIFO has its own registered data lane.

Parameters:
- DATA_W, 6, width of each stored word.
- DEPTH, 8, entries per FIFO; must be a power of 2 and at least 4.
- AF_THRESH, 6, Almost_full asserts when occupancy >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Push  input  4  push strobe per FIFO; bit i writes data_in into FIFO i.
- data_in  input  DATA_W  shared write data.
- Pop  input  4  pop strobe per FIFO from downstream.
- data_out  output  4*DATA_W  registered read data; lane i is bits [i*DATA_W +: DATA_W].
- FIFO_empty  output  4  bit i high when FIFO i occupancy == 0.
- Almost_full  output  4  bit i high when FIFO i occupancy >= AF_THRESH.
- FIFO_full  output  4  bit i high when FIFO i occupancy == DEPTH.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high and has priority over all other inputs.
- Reset state:
  - all read pointers, write pointers and counts = 0.
  - data_out = 0.
  - FIFO_empty = 4'b1111, Almost_full = 0, FIFO_full = 0.
  - Memory contents are not cleared.
- Reset mid-operation: all stored data is discarded; Push/Pop in the reset cycle are ignored.
- FIFOs are fully independent. Multiple Push bits set in one cycle write the same data_in into each selected FIFO (the arbiter normally drives one-hot).
- Push accepted (FIFO i not full): mem[wr_ptr] <= data_in; wr_ptr increments; count increments.
- Pop accepted (FIFO i not empty): data_out lane i <= mem[rd_ptr] on the same edge, so the word is visible from the next cycle; rd_ptr increments; count decrements.
- Pop on empty: ignored; lane i holds its previous value; no pointer change.
- Push on full without Pop: word dropped; pointers and count unchanged.
- Simultaneous Push and Pop:
  - Not empty (including full): both accepted; count unchanged; at full, the slot freed by the pop is refilled in the same cycle.
  - Empty: push accepted, pop ignored (no bypass); count becomes 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Status flags decode combinationally from the count registers, so they reflect state after the most recent edge (zero added latency).
- Almost_full timing: asserts in the cycle after the push that brings occupancy to AF_THRESH. The arbiter must stop pushing that FIFO then; DEPTH-AF_THRESH entries of slack absorb its pipeline.
- Write-to-read latency: a word pushed at edge k can be popped at edge k+1 at the earliest and appears on data_out after edge k+1.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds output err_overflow [3:0] and output err_underflow [3:0].
  - Bit i sets on the edge where a push to full FIFO i (without a simultaneous pop) is dropped, or a pop of empty FIFO i is ignored.
  - Bits are sticky until reset; reset value 0.
- Undefined: ports absent; drops and ignored pops are silent, otherwise identical behaviour.

Test Plan:
- Reset then idle 3 cycles -> FIFO_empty=4'b1111, Almost_full=0, FIFO_full=0, data_out=0.
- Push=4'b0010 with data_in 1,2,3 on consecutive cycles, then Pop=4'b0010 for 3 cycles -> lane1 reads 1,2,3 each one cycle after its pop; FIFO_empty[1] returns to 1 after the third pop.
- 6 pushes into FIFO 2 -> Almost_full[2] rises exactly after the 6th push. 2 more pushes -> FIFO_full[2]=1. A 9th push (value 0x3F) -> dropped; err_overflow[2]=1 with FIFO_ERR_FLAGS_EN. Draining 8 pops -> original 8 values in order, 0x3F never appears.
- FIFO 0 full, Push=Pop=4'b0001 with data_in 0x2A for one cycle -> count stays 8; 0x2A is read last after a full drain.
- FIFO 3 empty, Push=Pop=4'b1000 -> pop ignored, lane3 unchanged, count=1, FIFO_empty[3]=0. Pop on empty FIFO 1 -> err_underflow[1]=1.
- 4 entries in FIFO 0, assert reset for 1 cycle with Push=4'b0001 -> FIFO_empty[0]=1, data_out=0. Pushing 0x15 then popping returns 0x15.

Source files
------------

// File: rtl/fifo_bank_salida.sv
// Four independent output FIFOs with shared write data, per-FIFO pop and a registered read lane each.
// Optional sticky error flags are enabled with the FIFO_ERR_FLAGS_EN macro.
module fifo_bank_salida #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            Push,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [3:0]            Pop,
  output logic [4*DATA_W-1:0]   data_out,
  output logic [3:0]            FIFO_empty,
  output logic [3:0]            Almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic [3:0]            FIFO_full,
  output logic [3:0]            err_overflow,
  output logic [3:0]            err_underflow
`else
  output logic [3:0]            FIFO_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              empty, full, push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    // A pop frees a slot on the same edge, so a full FIFO still accepts a push paired with a pop.
    assign pop_ok  = Pop[g] && !empty;
    assign push_ok = Push[g] && (!full || pop_ok);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        dout_q   <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        dout_q   <= dout_d;
      end
    end

    // NOTE: storage has no reset; zeroed pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
      if (!reset && push_ok) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out[g*DATA_W +: DATA_W] = dout_q;
    assign FIFO_empty[g]  = empty;
    assign FIFO_full[g]   = full;
    assign Almost_full[g] = (count_q >= CNT_W'(AF_THRESH));

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (Push[g] && !push_ok) ovf_q <= 1'b1;
        if (Pop[g] && empty)     unf_q <= 1'b1;
      end
    end

    assign err_overflow[g]  = ovf_q;
    assign err_underflow[g] = unf_q;
`endif
  end

endmodule

// File: tb/tb_fifo_bank_salida.sv
// Directed bench for fifo_bank_salida: a vector table for reset and a basic push/pop run,
// then hand-written sequences for full, simultaneous push/pop, empty and mid-run reset cases.
module tb_fifo_bank_salida;

  localparam int DW = 6;

  logic          clk;
  logic          reset;
  logic [3:0]    Push;
  logic [DW-1:0] data_in;
  logic [3:0]    Pop;
  logic [4*DW-1:0] data_out;
  logic [3:0]    FIFO_empty, Almost_full, FIFO_full;
`ifdef FIFO_ERR_FLAGS_EN
  logic [3:0]    err_overflow, err_underflow;
`endif

  fifo_bank_salida #(.DATA_W(DW), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .Push        (Push),
    .data_in     (data_in),
    .Pop         (Pop),
    .data_out    (data_out),
    .FIFO_empty  (FIFO_empty),
    .Almost_full (Almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .FIFO_full   (FIFO_full),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
`else
    .FIFO_full   (FIFO_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  push;
    logic [3:0]  pop;
    logic [5:0]  din;
    logic [3:0]  exp_empty;
    logic [3:0]  exp_af;
    logic [3:0]  exp_full;
    logic [23:0] exp_dout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Applies one cycle of inputs, waits for the edge, then returns 1ns later with inputs idle.
  task automatic step(input logic r, input logic [3:0] pu, input logic [3:0] po, input logic [5:0] d);
    reset   = r;
    Push    = pu;
    Pop     = po;
    data_in = d;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    Push    = '0;
    Pop     = '0;
    data_in = '0;
  endtask

  function automatic logic [5:0] lane(input int k);
    return data_out[k*DW +: DW];
  endfunction

  vec_t vecs [10];

  initial begin
    reset = 1'b1; Push = '0; Pop = '0; data_in = '0;

    //          rst   push     pop      din  empty    af       full     dout
    vecs[0] = '{1'b1, 4'b0000, 4'b0000, 6'd0, 4'b1111, 4'b0000, 4'b0000, 24'h000000};
    vecs[1] = '{1'b0, 4'b0000, 4'b0000, 6'd0, 4'b1111, 4'b0000, 4'b0000, 24'h000000};
    vecs[2] = '{1'b0, 4'b0000, 4'b0000, 6'd0, 4'b1111, 4'b0000, 4'b0000, 24'h000000};
    vecs[3] = '{1'b0, 4'b0000, 4'b0000, 6'd0, 4'b1111, 4'b0000, 4'b0000, 24'h000000};
    vecs[4] = '{1'b0, 4'b0010, 4'b0000, 6'd1, 4'b1101, 4'b0000, 4'b0000, 24'h000000};
    vecs[5] = '{1'b0, 4'b0010, 4'b0000, 6'd2, 4'b1101, 4'b0000, 4'b0000, 24'h000000};
    vecs[6] = '{1'b0, 4'b0010, 4'b0000, 6'd3, 4'b1101, 4'b0000, 4'b0000, 24'h000000};
    vecs[7] = '{1'b0, 4'b0000, 4'b0010, 6'd0, 4'b1101, 4'b0000, 4'b0000, 24'h000040};
    vecs[8] = '{1'b0, 4'b0000, 4'b0010, 6'd0, 4'b1101, 4'b0000, 4'b0000, 24'h000080};
    vecs[9] = '{1'b0, 4'b0000, 4'b0010, 6'd0, 4'b1111, 4'b0000, 4'b0000, 24'h0000C0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
      check($sformatf("vec%0d empty", i), 32'(FIFO_empty),  32'(vecs[i].exp_empty));
      check($sformatf("vec%0d af", i),    32'(Almost_full), 32'(vecs[i].exp_af));
      check($sformatf("vec%0d full", i),  32'(FIFO_full),   32'(vecs[i].exp_full));
      check($sformatf("vec%0d dout", i),  32'(data_out),    32'(vecs[i].exp_dout));
    end

    // FIFO 2: fill to full watching Almost_full, drop a ninth word, drain in order.
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf before", 32'(err_overflow), 32'h0);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0100, 4'b0000, 6'(20 + i));
      check($sformatf("f2 af n=%0d", i + 1),   32'(Almost_full[2]), 32'((i + 1) >= 6));
      check($sformatf("f2 full n=%0d", i + 1), 32'(FIFO_full[2]),   32'((i + 1) == 8));
    end
    step(1'b0, 4'b0100, 4'b0000, 6'h3F);
    check("f2 full after drop", 32'(FIFO_full[2]), 32'h1);
`ifdef FIFO_ERR_FLAGS_EN
    check("f2 overflow", 32'(err_overflow), 32'h4);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0000, 4'b0100, 6'd0);
      check($sformatf("f2 drain %0d", i), 32'(lane(2)), 32'(20 + i));
    end
    check("f2 empty after drain", 32'(FIFO_empty[2]), 32'h1);
    step(1'b0, 4'b0000, 4'b0100, 6'd0);
    check("f2 pop empty holds", 32'(lane(2)), 32'd27);
    check("f1 lane untouched", 32'(lane(1)), 32'd3);

    // FIFO 0: full, then simultaneous push/pop refills the freed slot.
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 4'b0000, 6'(30 + i));
    check("f0 full", 32'(FIFO_full[0]), 32'h1);
    step(1'b0, 4'b0001, 4'b0001, 6'h2A);
    check("f0 pp lane", 32'(lane(0)), 32'd30);
    check("f0 pp still full", 32'(FIFO_full[0]), 32'h1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 4'b0000, 4'b0001, 6'd0);
      check($sformatf("f0 drain %0d", i), 32'(lane(0)), 32'(30 + i));
    end
    check("f0 not empty before last", 32'(FIFO_empty[0]), 32'h0);
    step(1'b0, 4'b0000, 4'b0001, 6'd0);
    check("f0 last is 2A", 32'(lane(0)), 32'h2A);
    check("f0 empty", 32'(FIFO_empty[0]), 32'h1);

    // FIFO 3 empty: push+pop only pushes; pop on empty FIFO 1 is ignored.
    step(1'b0, 4'b1000, 4'b1000, 6'h11);
    check("f3 lane unchanged", 32'(lane(3)), 32'h0);
    check("f3 not empty", 32'(FIFO_empty[3]), 32'h0);
    check("f3 af", 32'(Almost_full[3]), 32'h0);
    step(1'b0, 4'b0000, 4'b0010, 6'd0);
    check("f1 pop empty holds", 32'(lane(1)), 32'd3);
`ifdef FIFO_ERR_FLAGS_EN
    check("f1 underflow", 32'(err_underflow[1]), 32'h1);
`endif
    step(1'b0, 4'b0000, 4'b1000, 6'd0);
    check("f3 pop", 32'(lane(3)), 32'h11);
    check("f3 empty after pop", 32'(FIFO_empty[3]), 32'h1);

    // Reset with data stored and a push in the reset cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 4'b0000, 6'(1 + i));
    check("f0 four stored", 32'(FIFO_empty[0]), 32'h0);
    step(1'b1, 4'b0001, 4'b0000, 6'd9);
    check("rst empty", 32'(FIFO_empty), 32'hF);
    check("rst dout", 32'(data_out), 32'h0);
    check("rst full", 32'(FIFO_full), 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rst ovf", 32'(err_overflow), 32'h0);
    check("rst unf", 32'(err_underflow), 32'h0);
`endif
    step(1'b0, 4'b0001, 4'b0000, 6'h15);
    step(1'b0, 4'b0000, 4'b0001, 6'd0);
    check("post rst pop", 32'(lane(0)), 32'h15);
    check("post rst empty", 32'(FIFO_empty[0]), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
